// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Debounce and conditioning stage for the button channel of the input mux.
// Each raw active-low pin passes through a two-flop synchronizer and is then
// filtered per bit. A new level is accepted only after DB_CYCLES consecutive
// samples that disagree with the current state. The block presents a clean
// active-high button vector and one-cycle press/release strobes.
//
// Optional feature macro: BTN_TURBO_EN
//   Defined   : a free-running phase generator gates btn_out per bit
//               (autofire) wherever turbo_mask is set.
//   Undefined : btn_out is a plain registered copy of the debounced state and
//               turbo_mask is ignored.
//
// Parameters:
//   WIDTH      number of button lines (1..16)
//   DB_CYCLES  consecutive stable cycles needed to accept a new level (>= 2)
//   TURBO_HALF clk cycles per autofire half-period (>= 1)
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   btn_n_in      raw button pins, active-low, asynchronous to clk
//   turbo_mask    per-bit autofire enable (quasi-static)
//   btn_out       debounced active-high state (turbo-gated when enabled)
//   press_pulse   one-cycle strobe per bit on an accepted press
//   release_pulse one-cycle strobe per bit on an accepted release
//   changed       OR of all press/release strobes, same cycle
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DB_CYCLES  = 100,
    parameter int unsigned TURBO_HALF = 500
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_n_in,
    input  logic [WIDTH-1:0] turbo_mask,
    output logic [WIDTH-1:0] btn_out,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic             changed
);

    localparam int unsigned   CNT_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    // Synchronizer flops; reset to all-ones so every line starts released.
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    // Debounced state, previous-cycle copy for edge strobes, per-bit counters.
    logic [WIDTH-1:0] st_q;
    logic [WIDTH-1:0] st_d;
    logic [WIDTH-1:0] st_prev;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    logic [WIDTH-1:0] sample_c;
    logic [WIDTH-1:0] rise_c;
    logic [WIDTH-1:0] fall_c;
    logic [WIDTH-1:0] gate_c;

    assign sample_c = ~sync2;

    // Per-bit filter: any agreeing sample clears the run; the DB_CYCLES-th
    // consecutive disagreeing sample flips the state.
    always_comb begin
        st_d = st_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sample_c[i] != st_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    st_d[i] = sample_c[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // st_prev lags st_q by one cycle, so a flip shows up as a one-cycle
    // difference that is registered into the strobe outputs. Reset clears
    // both, so reset can never create a strobe.
    assign rise_c = st_q & ~st_prev;
    assign fall_c = ~st_q & st_prev;

`ifdef BTN_TURBO_EN
    localparam int unsigned   TC_W   = (TURBO_HALF > 1) ? $clog2(TURBO_HALF) : 1;
    localparam logic [TC_W-1:0] TC_MAX = TC_W'(TURBO_HALF - 1);

    logic [TC_W-1:0] tcnt_q;
    logic            phase_q;

    // Free-running autofire phase: toggles each time the counter wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q  <= '0;
            phase_q <= 1'b1;
        end else if (tcnt_q == TC_MAX) begin
            tcnt_q  <= '0;
            phase_q <= ~phase_q;
        end else begin
            tcnt_q  <= tcnt_q + TC_W'(1);
        end
    end

    assign gate_c = ~turbo_mask | {WIDTH{phase_q}};
`else
    logic unused_turbo_mask;

    assign unused_turbo_mask = ^turbo_mask;
    assign gate_c            = '1;
`endif

    // Synchronizer, filter state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1         <= '1;
            sync2         <= '1;
            st_q          <= '0;
            st_prev       <= '0;
            btn_out       <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            changed       <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1         <= btn_n_in;
            sync2         <= sync1;
            st_q          <= st_d;
            st_prev       <= st_q;
            btn_out       <= st_q & gate_c;
            press_pulse   <= rise_c;
            release_pulse <= fall_c;
            changed       <= |(rise_c | fall_c);
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// -----------------------------------------------------------------------------
// tb_button_debounce
//
// Self-checking bench for button_debounce (WIDTH=8, DB_CYCLES=4, TURBO_HALF=3).
// The reference model keeps a per-edge history of pins and resets and decides
// acceptance by the window rule: a bit flips at an edge when the last
// DB_CYCLES samples since reset all disagree with its current level.
// Autofire phase is derived arithmetically from the edge count since reset.
// Honours BTN_TURBO_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_button_debounce;

    localparam int unsigned W    = 8;
    localparam int unsigned DB   = 4;
    localparam int unsigned TH   = 3;
    localparam int          MAXK = 2048;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] btn_n_in;
    logic [W-1:0] turbo_mask;
    logic [W-1:0] btn_out;
    logic [W-1:0] press_pulse;
    logic [W-1:0] release_pulse;
    logic         changed;

    button_debounce #(
        .WIDTH      (W),
        .DB_CYCLES  (DB),
        .TURBO_HALF (TH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_n_in      (btn_n_in),
        .turbo_mask    (turbo_mask),
        .btn_out       (btn_out),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .changed       (changed)
    );

    always #5 clk = ~clk;

    // Per-edge history used by the reference model.
    logic [W-1:0] pin_h  [MAXK];
    logic [W-1:0] mask_h [MAXK];
    logic [W-1:0] st_h   [MAXK];
    logic [W-1:0] rise_h [MAXK];
    logic [W-1:0] fall_h [MAXK];
    bit           rst_h  [MAXK];
    int           last_rst = 0;
    int           k        = 0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    // Active-high level the filter sees at edge j: the pin captured two edges
    // earlier, or released if a reset hit the synchronizer in between.
    function automatic logic [W-1:0] sample_at(input int j);
        if (j < 2) return '0;
        if (rst_h[j-1] || rst_h[j-2]) return '0;
        return ~pin_h[j-2];
    endfunction

    task automatic model_and_check();
        logic [W-1:0] e_btn;
        logic [W-1:0] e_pr;
        logic [W-1:0] e_rl;
        logic [W-1:0] smp;
        bit           all_diff;
`ifdef BTN_TURBO_EN
        bit           ph;
`endif
        if (rst_h[k]) begin
            st_h[k]   = '0;
            rise_h[k] = '0;
            fall_h[k] = '0;
            last_rst  = k;
            e_btn     = '0;
            e_pr      = '0;
            e_rl      = '0;
        end else begin
            st_h[k]   = st_h[k-1];
            rise_h[k] = '0;
            fall_h[k] = '0;
            if (k - last_rst >= int'(DB)) begin
                for (int b = 0; b < int'(W); b++) begin
                    all_diff = 1'b1;
                    for (int j = k - int'(DB) + 1; j <= k; j++) begin
                        smp = sample_at(j);
                        if (smp[b] == st_h[k-1][b]) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        st_h[k][b] = ~st_h[k-1][b];
                        if (st_h[k][b]) rise_h[k][b] = 1'b1;
                        else            fall_h[k][b] = 1'b1;
                    end
                end
            end
`ifdef BTN_TURBO_EN
            ph    = (((k - 1 - last_rst) / int'(TH)) % 2) == 0;
            e_btn = st_h[k-1] & (~mask_h[k] | {W{ph}});
`else
            e_btn = st_h[k-1];
`endif
            e_pr = rise_h[k-1];
            e_rl = fall_h[k-1];
        end
        check("btn_out",       32'(btn_out),       32'(e_btn));
        check("press_pulse",   32'(press_pulse),   32'(e_pr));
        check("release_pulse", 32'(release_pulse), 32'(e_rl));
        check("changed",       32'(changed),       32'(|(e_pr | e_rl)));
    endtask

    // One clock: drive on the falling edge, check 1 time unit after the rise.
    task automatic step(input bit r, input logic [W-1:0] pin, input logic [W-1:0] m);
        @(negedge clk);
        reset      = r;
        btn_n_in   = pin;
        turbo_mask = m;
        pin_h[k]   = pin;
        rst_h[k]   = r;
        mask_h[k]  = m;
        @(posedge clk);
        #1;
        model_and_check();
        k++;
    endtask

    initial begin
        int           p3;
        int           p1;
        int           hold;
        bit           r;
        logic [W-1:0] pv;
        logic [W-1:0] mv;

        reset      = 1'b1;
        btn_n_in   = '1;
        turbo_mask = '0;

        // Reset with all pins pressed, then release reset and let them settle.
        repeat (3)  step(1'b1, 8'h00, 8'h00);
        repeat (10) step(1'b0, 8'h00, 8'h00);
        repeat (10) step(1'b0, 8'hFF, 8'h00);

        // Clean press and release of bit 0.
        repeat (10) step(1'b0, 8'hFE, 8'h00);
        repeat (10) step(1'b0, 8'hFF, 8'h00);

        // Bounce on bit 3, then a stable press: exactly one press strobe.
        p3 = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, (i % 2 == 0) ? 8'hF7 : 8'hFF, 8'h00);
            if (press_pulse[3]) p3++;
        end
        check("bounce_no_strobe", 32'(p3), 32'd0);
        repeat (10) begin
            step(1'b0, 8'hF7, 8'h00);
            if (press_pulse[3]) p3++;
        end
        check("bounce_one_press", 32'(p3), 32'd1);
        repeat (10) step(1'b0, 8'hFF, 8'h00);

        // Simultaneous press of bits 1 and 7.
        p1 = 0;
        repeat (10) begin
            step(1'b0, 8'h7D, 8'h00);
            if (changed) p1++;
        end
        check("simul_changed_count", 32'(p1), 32'd1);
        repeat (10) step(1'b0, 8'hFF, 8'h00);

        // Press bit 2, reset mid-count, keep the pin held through and after.
        repeat (2)  step(1'b0, 8'hFB, 8'h00);
        repeat (2)  step(1'b1, 8'hFB, 8'h00);
        repeat (10) step(1'b0, 8'hFB, 8'h00);
        repeat (10) step(1'b0, 8'hFF, 8'h00);

        // Autofire on bit 0, then the same hold with autofire disabled.
        repeat (15) step(1'b0, 8'hFE, 8'h01);
        repeat (8)  step(1'b0, 8'hFE, 8'h00);
        repeat (10) step(1'b0, 8'hFF, 8'h00);

        // Randomized pin activity with occasional resets and mask changes.
        pv = 8'hFF;
        mv = 8'h00;
        while (k < 1500) begin
            pv   = pv ^ (W'($urandom) & W'($urandom));
            hold = $urandom_range(1, 7);
            r    = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 4) == 0) mv = W'($urandom);
            repeat (hold) begin
                step(r, pv, mv);
                r = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
